// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives the two select lines of a 2-to-4 decoder,
// either free-running (one code step every PRESCALE clocks) or single-stepped
// from the rising edge of Step.
// Latency: code, Valid and Wrap update on the edge that performs the advance;
//          every output comes straight from a flop, so no input-to-output path.
// Backpressure: none; Step is a four-phase handshake acknowledged by Step_ack.
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst      in   asynchronous active-high reset
//   Run      in   level enable for free-running scan
//   Step     in   single-step request (rising edge advances once)
//   Dir      in   0 = count up, 1 = count down (sampled at the advance edge)
//   In1/In2  out  registered select code, In1 is the MSB
//   Valid    out  one-cycle pulse in the cycle after each code change
//   Wrap     out  pulse alongside Valid when the change was 3->0 or 0->3
//   Step_ack out  high while a step handshake is in progress
//
// PRESCALE must lie in 1..255; the prescaler is 8 bits wide.

module decoder_scan_sequencer #(
    parameter int PRESCALE = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Run,
    input  logic Step,
    input  logic Dir,
    output logic In1,
    output logic In2,
    output logic Valid,
    output logic Wrap,
    output logic Step_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    localparam logic [7:0] PRESCALE_LAST = 8'(PRESCALE - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic [1:0] code_q,  code_d;
    logic       step_q,  step_d;
    logic       valid_q, valid_d;
    logic       wrap_q,  wrap_d;

    logic       rise;
    logic       advance;
    logic [1:0] code_next;
    logic       code_wraps;

    // Step history resets to 1 so a Step held high across reset release
    // does not look like a fresh request.
    assign rise = Step & ~step_q;

    // Next code and wrap flag for the current Dir; only used on an advance.
    always_comb begin
        code_next  = code_q;
        code_wraps = 1'b0;
        if (Dir) begin
            code_next  = code_q - 2'd1;
            code_wraps = (code_q == 2'd0);
        end else begin
            code_next  = code_q + 2'd1;
            code_wraps = (code_q == 2'd3);
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        advance = 1'b0;
        step_d  = Step;

        case (state_q)
            S_IDLE: begin
                // Run has priority over a coincident step edge; the edge is dropped.
                if (Run) begin
                    state_d = S_RUN;
                    presc_d = 8'd0;
                end else if (rise) begin
                    advance = 1'b1;
                    state_d = S_STEP;
                end
            end

            S_RUN: begin
                // Losing Run wins even on the terminal prescaler count.
                if (!Run) begin
                    state_d = S_IDLE;
                    presc_d = 8'd0;
                end else if (presc_q == PRESCALE_LAST) begin
                    advance = 1'b1;
                    presc_d = 8'd0;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end

            S_STEP: begin
                // Hold the acknowledge until the requester drops Step; Run is
                // deliberately not looked at here.
                if (!Step) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                presc_d = 8'd0;
            end
        endcase

        code_d  = advance ? code_next : code_q;
        valid_d = advance;
        wrap_d  = advance & code_wraps;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            presc_q <= 8'd0;
            code_q  <= 2'd0;
            step_q  <= 1'b1;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            code_q  <= code_d;
            step_q  <= step_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign In1      = code_q[1];
    assign In2      = code_q[0];
    assign Valid    = valid_q;
    assign Wrap     = wrap_q;
    assign Step_ack = (state_q == S_STEP);

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed stimulus on two instances (PRESCALE=4 and
// PRESCALE=1); expected advances are queued by the driver and a negedge
// monitor per instance compares each Valid pulse against the queue head.

module tb_decoder_scan_sequencer;

    localparam int P0 = 4;

    typedef struct {
        int cyc;
        int code;
        int wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic run = 1'b0, step = 1'b0, dir = 1'b0;
    logic in1, in2, valid, wrap, step_ack;

    logic run1 = 1'b0, step1 = 1'b0, dir1 = 1'b0;
    logic in1_1, in2_1, valid_1, wrap_1, step_ack_1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int exp_code0 = 0;
    int exp_code1 = 0;

    exp_t q0[$];
    exp_t q1[$];

    decoder_scan_sequencer #(.PRESCALE(P0)) u_dut0 (
        .Clk(clk), .Rst(rst), .Run(run), .Step(step), .Dir(dir),
        .In1(in1), .In2(in2), .Valid(valid), .Wrap(wrap), .Step_ack(step_ack)
    );

    decoder_scan_sequencer #(.PRESCALE(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .Run(run1), .Step(step1), .Dir(dir1),
        .In1(in1_1), .In2(in2_1), .Valid(valid_1), .Wrap(wrap_1), .Step_ack(step_ack_1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input int at_cyc, input logic d);
        exp_t e;
        int nxt;
        nxt = d ? (exp_code0 + 3) % 4 : (exp_code0 + 1) % 4;
        e.cyc  = at_cyc;
        e.code = nxt;
        e.wrap = d ? int'(exp_code0 == 0) : int'(exp_code0 == 3);
        exp_code0 = nxt;
        q0.push_back(e);
    endtask

    task automatic push1(input int at_cyc);
        exp_t e;
        int nxt;
        nxt = (exp_code1 + 1) % 4;
        e.cyc  = at_cyc;
        e.code = nxt;
        e.wrap = int'(exp_code1 == 3);
        exp_code1 = nxt;
        q1.push_back(e);
    endtask

    // Enter RUN on the next edge (E0) and stay through n full slots; the
    // k-th advance lands on edge E0 + k*P0. Leaves Run asserted.
    task automatic run0(input int n, input logic d, input logic s);
        int c;
        dir  = d;
        step = s;
        run  = 1'b1;
        c = cyc;
        for (int k = 1; k <= n; k++) push0(c + 1 + k * P0, d);
        tick(1 + n * P0);
    endtask

    task automatic stop0();
        run = 1'b0;
        tick(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid0: got valid=1 code=%0d expected no advance (cycle %0d)",
                         int'({in1, in2}), cyc);
            end else begin
                e = q0.pop_front();
                check("adv0_cycle", cyc, e.cyc);
                check("adv0_code", int'({in1, in2}), e.code);
                check("adv0_wrap", int'(wrap), e.wrap);
            end
        end else if (wrap) begin
            checks++;
            errors++;
            $display("FAIL wrap0_without_valid: got wrap=1 expected 0 (cycle %0d)", cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid_1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid1: got valid=1 code=%0d expected no advance (cycle %0d)",
                         int'({in1_1, in2_1}), cyc);
            end else begin
                e = q1.pop_front();
                check("adv1_cycle", cyc, e.cyc);
                check("adv1_code", int'({in1_1, in2_1}), e.code);
                check("adv1_wrap", int'(wrap_1), e.wrap);
            end
        end else if (wrap_1) begin
            checks++;
            errors++;
            $display("FAIL wrap1_without_valid: got wrap=1 expected 0 (cycle %0d)", cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;

        // Asynchronous reset, observed before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_in1", int'(in1), 0);
        check("rst_in2", int'(in2), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_step_ack", int'(step_ack), 0);
        check("rst_code1", int'({in1_1, in2_1}), 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Free run up, PRESCALE=4: 0->1->2->3->0, wrap on the last.
        run0(4, 1'b0, 1'b0);
        stop0();
        check("run_up_code", int'({in1, in2}), 0);

        // Single step down from 0: one advance to 3 with wrap, ack until Step low.
        dir  = 1'b1;
        step = 1'b1;
        c = cyc;
        push0(c + 1, 1'b1);
        tick(1);
        check("step_ack_set", int'(step_ack), 1);
        tick(2);
        check("step_ack_held", int'(step_ack), 1);
        step = 1'b0;
        tick(1);
        check("step_ack_clr", int'(step_ack), 0);
        check("step_code", int'({in1, in2}), 3);
        tick(2);

        // Run and step edge together in IDLE: Run wins, first advance at E0+4.
        run0(1, 1'b0, 1'b1);
        stop0();
        step = 1'b0;
        tick(1);

        // Drop Run on the terminal prescaler count: no advance.
        dir = 1'b0;
        run = 1'b1;
        tick(4);
        run = 1'b0;
        tick(4);
        check("abort_code", int'({in1, in2}), 0);
        check("abort_step_ack", int'(step_ack), 0);
        // Re-entering RUN needs a full slot.
        run0(1, 1'b0, 1'b0);
        stop0();

        // Free run down through 0->3.
        run0(2, 1'b1, 1'b0);
        stop0();
        check("run_down_code", int'({in1, in2}), 3);

        // PRESCALE=1: advance on every edge, Valid continuous.
        dir1 = 1'b0;
        run1 = 1'b1;
        c = cyc;
        for (int k = 1; k <= 8; k++) push1(c + 1 + k);
        tick(9);
        run1 = 1'b0;
        tick(2);
        check("p1_code", int'({in1_1, in2_1}), 0);

        // Reset mid-RUN at code 2 with Step held high.
        run0(3, 1'b0, 1'b0);
        check("pre_rst_code", int'({in1, in2}), 2);
        step = 1'b1;
        tick(1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_in1", int'(in1), 0);
        check("mid_rst_in2", int'(in2), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_wrap", int'(wrap), 0);
        check("mid_rst_step_ack", int'(step_ack), 0);
        exp_code0 = 0;
        exp_code1 = 0;
        run = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
        check("post_rst_no_adv", int'({in1, in2}), 0);
        check("post_rst_step_ack", int'(step_ack), 0);

        // A fresh 0->1 on Step is needed to advance.
        step = 1'b0;
        tick(1);
        dir  = 1'b0;
        step = 1'b1;
        c = cyc;
        push0(c + 1, 1'b0);
        tick(1);
        check("fresh_step_ack", int'(step_ack), 1);
        step = 1'b0;
        tick(2);
        check("fresh_step_ack_clr", int'(step_ack), 0);
        check("fresh_step_code", int'({in1, in2}), 1);

        tick(3);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_scan_sequencer.md
DECODER_SCAN_SEQUENCER -- requirements
Module: decoder_scan_sequencer

Interface
REQ-001 Parameter: PRESCALE, default 4, clock cycles per select slot in RUN; legal range 1..255.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 Run  input  1  free-run enable; level-sensitive.
REQ-005 Step  input  1  single-step request; rising edge advances code once.
REQ-006 Dir  input  1  0 = count up (0,1,2,3,0...), 1 = count down (3,2,1,0,3...).
REQ-007 In1  output  1  select MSB; drives 2-to-4 decoder In1.
REQ-008 In2  output  1  select LSB; drives 2-to-4 decoder In2.
REQ-009 Valid  output  1  one-cycle pulse, high for the cycle after any code change.
REQ-010 Wrap  output  1  one-cycle pulse coincident with Valid when the change was 3->0 (up) or 0->3 (down).
REQ-011 Step_ack  output  1  high while the step handshake is in progress (STEP state).

Function
REQ-012 Code {In1,In2} SHALL be a registered 2-bit value; In1 is MSB; arithmetic is modulo 4.
REQ-013 States SHALL be IDLE, RUN, STEP; encoding is free.
REQ-014 Step edge detect: step_q SHALL register Step each cycle; rise = Step & ~step_q.
REQ-015 IDLE: code held; Run=1 -> RUN with prescaler cleared to 0; else rise -> advance code per Dir at that edge, go to STEP; else stay.
REQ-016 IDLE with Run=1 and rise at the same edge: Run SHALL win; no step advance; rise is discarded.
REQ-017 RUN: prescaler SHALL count 0..PRESCALE-1; at an edge where prescaler = PRESCALE-1 and Run=1, code advances per Dir and prescaler returns to 0.
REQ-018 RUN entered at edge E0: first advance at edge E0+PRESCALE, then every PRESCALE edges; PRESCALE=1 advances every edge.
REQ-019 RUN with Run=0 sampled: go to IDLE, clear prescaler, no advance, even if prescaler = PRESCALE-1.
REQ-020 RUN: Step and rise SHALL be ignored.
REQ-021 STEP: Step_ack=1; stay while Step=1; Step=0 -> IDLE. Run SHALL be ignored in STEP.
REQ-022 Valid SHALL be registered: high exactly one cycle after each advance edge, else 0; back-to-back advances (PRESCALE=1) give continuous Valid.
REQ-023 Wrap SHALL be registered with Valid, high only when that advance wrapped per REQ-010.
REQ-024 Dir SHALL be sampled at the advance edge only; changing Dir mid-slot affects the next advance only.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 Rst=1 SHALL immediately force: In1=0, In2=0, Valid=0, Wrap=0, Step_ack=0, state IDLE, prescaler 0, step_q 1.
REQ-027 step_q reset to 1: Step held high through reset release SHALL NOT cause an advance; a fresh 0->1 is required.
REQ-028 Rst asserted mid-RUN or mid-STEP SHALL abort with REQ-026 values, no Valid or Wrap pulse after release.

Verification
REQ-029 Reset, Run=1, Dir=0, PRESCALE=4 -> code 0,1,2,3,0 at edges E0+4,+8,+12,+16; Valid pulse after each; Wrap only after 3->0.
REQ-030 IDLE code 0, Dir=1, Step 0->1 held 3 cycles then 0 -> code 3 after one edge, Valid=1 and Wrap=1 one cycle, Step_ack high until Step=0 sampled, exactly one advance.
REQ-031 Run=1 and Step rise at the same edge in IDLE -> RUN entered, code unchanged at that edge, first advance at E0+PRESCALE.
REQ-032 RUN, PRESCALE=4, Run dropped at the edge where prescaler=3 -> no advance, IDLE, Valid stays 0; Run=1 again -> full 4-cycle slot before next advance.
REQ-033 PRESCALE=1, Run=1, Dir=0 -> code advances every edge, Valid continuously 1, Wrap every 4th cycle.
REQ-034 Step held 1 across Rst pulse mid-RUN at code 2 -> outputs 0 asynchronously; after release no advance until Step goes 0 then 1.
